storage_controller: RTL and testbench

STORAGE_CONTROLLER -- requirements
Module: storage_controller

---
 rtl/storage_controller_pkg.sv | 34 +++
 rtl/storage_spi_reader.sv | 93 +++++++++
 rtl/storage_controller.sv | 151 +++++++++++++++
 tb/tb_storage_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/storage_controller_pkg.sv
// Shared constants, FSM state encoding and a byte-order helper for the
// storage controller and its SPI read engine.
package storage_controller_pkg;

    // Internal SRAM geometry: 2048 words of 32 bits, word-addressed.
    localparam int SRAM_DEPTH = 2048;
    localparam int SRAM_AW    = 11;

    // Word addresses at or above this value go to the external SPI flash.
    localparam logic [31:0] EXT_BASE = 32'h800;

    // Standard serial-flash "read data" opcode.
    localparam logic [7:0] SPI_READ_CMD = 8'h03;

    // Top-level controller states. The SPI read engine reports its progress
    // using the SPI_* members of the same type.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SRAM_ACCESS  = 3'd1,
        ST_SPI_CMD      = 3'd2,
        ST_SPI_ADDR     = 3'd3,
        ST_SPI_DATA     = 3'd4,
        ST_DONE         = 3'd5,
        ST_WAIT_RELEASE = 3'd6
    } state_t;

    // The flash streams bytes in order; the first byte received belongs in
    // bits [7:0] of the returned word, so the shift register is reversed
    // byte-wise.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/storage_spi_reader.sv
// SPI mode-0 read engine: sends the read opcode and a 24-bit byte address,
// then shifts in one 32-bit word. sck runs at clk/2.
//
// Handshake: start is a single-cycle request accepted only while the engine
// is inactive; done is a single-cycle pulse issued after cs_n has been
// raised, and data stays stable from done until the next start.
module storage_spi_reader
    import storage_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic [21:0] word_addr,
    input  logic        miso,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [31:0] data,
    output state_t      phase
);

    // 32 bits out (opcode + address) followed by 32 bits in.
    localparam logic [5:0] LAST_BIT = 6'd63;

    logic        active;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;

    // Serial engine: one sck period is two clk cycles (rise, then fall).
    // mosi changes on the falling half, miso is captured on the rising half.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active  <= 1'b0;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    cs_n    <= 1'b0;
                    sck     <= 1'b0;
                    tx_sr   <= {SPI_READ_CMD, word_addr, 2'b00};
                    mosi    <= SPI_READ_CMD[7];
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                end
            end else if (!sck) begin
                sck <= 1'b1;
                // Upper half of the bit count is the data phase.
                if (bit_cnt[5]) begin
                    rx_sr <= {rx_sr[30:0], miso};
                end
            end else begin
                sck     <= 1'b0;
                tx_sr   <= {tx_sr[30:0], 1'b0};
                mosi    <= tx_sr[30];
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == LAST_BIT) begin
                    active <= 1'b0;
                    cs_n   <= 1'b1;
                    mosi   <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Report which part of the frame is on the wire.
    always_comb begin
        phase = ST_IDLE;
        if (active) begin
            if (bit_cnt < 6'd8) begin
                phase = ST_SPI_CMD;
            end else if (bit_cnt < 6'd32) begin
                phase = ST_SPI_ADDR;
            end else begin
                phase = ST_SPI_DATA;
            end
        end
    end

    assign data = byte_swap(rx_sr);

endmodule

// File: rtl/storage_controller.sv
// Storage controller: 2048x32 internal SRAM below EXT_BASE, read-only SPI
// flash above it, and a passthrough that lends the flash bus to an external
// programmer while set_programming_mode is high.
//
// Handshake: memory_access is a level request. It is accepted in IDLE,
// address/data/direction are taken at that edge, and out_valid pulses once.
// The requester must drop memory_access before another request is accepted.
module storage_controller
    import storage_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_access,
    input  logic        memory_is_writing,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic [3:0]  mem_be,
    output logic [31:0] d_out,
    output logic        out_valid,
    input  logic        set_programming_mode,
    input  logic        programming_spi_cs_n,
    input  logic        programming_spi_sck,
    input  logic        programming_spi_mosi,
    output logic        programming_spi_miso,
    output logic        external_storage_spi_cs_n,
    output logic        external_storage_spi_sck,
    output logic        external_storage_spi_mosi,
    input  logic        external_storage_spi_miso,
    output state_t      dbg_state
);

    logic [31:0] mem [SRAM_DEPTH];

    state_t             state;
    logic               accept;
    logic               is_ext;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_idx;

    logic               rdr_start;
    logic               rdr_cs_n;
    logic               rdr_sck;
    logic               rdr_mosi;
    logic               rdr_done;
    logic [31:0]        rdr_data;
    state_t             rdr_phase;

    assign sram_idx  = addr[SRAM_AW-1:0];
    assign is_ext    = (addr >= EXT_BASE);
    assign accept    = (state == ST_IDLE) && memory_access && !set_programming_mode;
    assign sram_we   = accept && !is_ext && memory_is_writing && !rst;
    assign rdr_start = accept && is_ext && !memory_is_writing;
    assign dbg_state = state;

    storage_spi_reader u_reader (
        .clk       (clk),
        .rst       (rst),
        .abort     (set_programming_mode),
        .start     (rdr_start),
        .word_addr (addr[21:0]),
        .miso      (external_storage_spi_miso),
        .cs_n      (rdr_cs_n),
        .sck       (rdr_sck),
        .mosi      (rdr_mosi),
        .done      (rdr_done),
        .data      (rdr_data),
        .phase     (rdr_phase)
    );

    // Bus ownership: the programmer gets the flash pins with no added delay.
    always_comb begin
        external_storage_spi_cs_n = rdr_cs_n;
        external_storage_spi_sck  = rdr_sck;
        external_storage_spi_mosi = rdr_mosi;
        programming_spi_miso      = 1'b0;
        if (set_programming_mode) begin
            external_storage_spi_cs_n = programming_spi_cs_n;
            external_storage_spi_sck  = programming_spi_sck;
            external_storage_spi_mosi = programming_spi_mosi;
            programming_spi_miso      = external_storage_spi_miso;
        end
    end

    // SRAM byte-masked write at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[sram_idx][8*b +: 8] <= d_in[8*b +: 8];
                end
            end
        end
    end

    // Top-level FSM. out_valid is high exactly for the one cycle spent in
    // SRAM_ACCESS or DONE, so it is set on the edge that enters them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            d_out     <= '0;
            out_valid <= 1'b0;
        end else if (set_programming_mode) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (memory_access) begin
                        if (!is_ext) begin
                            state     <= ST_SRAM_ACCESS;
                            out_valid <= 1'b1;
                            if (!memory_is_writing) begin
                                d_out <= mem[sram_idx];
                            end
                        end else if (memory_is_writing) begin
                            // External writes are dropped without bus activity.
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_SPI_CMD;
                        end
                    end
                end
                ST_SRAM_ACCESS, ST_DONE: begin
                    state <= memory_access ? ST_WAIT_RELEASE : ST_IDLE;
                end
                ST_SPI_CMD, ST_SPI_ADDR, ST_SPI_DATA: begin
                    if (rdr_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        d_out     <= rdr_data;
                    end else if (rdr_phase == ST_IDLE) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= rdr_phase;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!memory_access) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_storage_controller.sv
// Bench for storage_controller: passthrough, SRAM sweep, byte enables,
// external flash reads against a bit-level flash model, random mixed
// traffic, and aborts by reset and by programming mode.
module tb_storage_controller;
    import storage_controller_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        memory_access = 1'b0;
    logic        memory_is_writing = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] d_in = '0;
    logic [3:0]  mem_be = '0;
    logic [31:0] d_out;
    logic        out_valid;
    logic        set_programming_mode = 1'b0;
    logic        prog_cs_n = 1'b1;
    logic        prog_sck = 1'b0;
    logic        prog_mosi = 1'b0;
    logic        prog_miso;
    logic        ext_cs_n;
    logic        ext_sck;
    logic        ext_mosi;
    logic        ext_miso;
    state_t      dbg_state;

    storage_controller dut (
        .clk                       (clk),
        .rst                       (rst),
        .memory_access             (memory_access),
        .memory_is_writing         (memory_is_writing),
        .addr                      (addr),
        .d_in                      (d_in),
        .mem_be                    (mem_be),
        .d_out                     (d_out),
        .out_valid                 (out_valid),
        .set_programming_mode      (set_programming_mode),
        .programming_spi_cs_n      (prog_cs_n),
        .programming_spi_sck       (prog_sck),
        .programming_spi_mosi      (prog_mosi),
        .programming_spi_miso      (prog_miso),
        .external_storage_spi_cs_n (ext_cs_n),
        .external_storage_spi_sck  (ext_sck),
        .external_storage_spi_mosi (ext_mosi),
        .external_storage_spi_miso (ext_miso),
        .dbg_state                 (dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    logic [31:0] sram_m [2048];
    logic [7:0]  f_bytes [4];
    logic [31:0] exp_q [$];
    logic        chk_q [$];

    // Flash model: counts sck rises inside a cs_n-low frame, captures the
    // first 32 mosi bits and streams f_bytes MSB-first after them.
    int          f_cnt = 0;
    int          sck_rises = 0;
    logic [31:0] f_cmd = '0;
    logic        f_miso = 1'b0;
    logic        pt_drive = 1'b0;
    logic        pt_miso = 1'b0;

    assign ext_miso = pt_drive ? pt_miso : f_miso;

    always @(posedge ext_sck or posedge ext_cs_n) begin
        if (ext_cs_n) begin
            f_cnt = 0;
        end else begin
            if (f_cnt < 32) f_cmd = {f_cmd[30:0], ext_mosi};
            f_cnt = f_cnt + 1;
            sck_rises = sck_rises + 1;
        end
    end

    always @(negedge ext_sck) begin
        int k;
        if (!ext_cs_n && f_cnt >= 32 && f_cnt < 64) begin
            k = f_cnt - 32;
            f_miso = f_bytes[k / 8][7 - (k % 8)];
        end
    end

    // ---------------- driver ----------------
    // One transaction: model update, drive, wait (bounded) for out_valid,
    // keep the request held for 'hold' extra cycles while scrambling the
    // inputs, then release and confirm exactly one completion.
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int hold);
        logic [31:0] e;
        logic        c;
        int          cyc;
        int          pulses;
        int          first;
        int          rises0;
        logic        ext;
        ext = (a >= 32'h800);
        e = '0;
        c = 1'b0;
        if (!ext) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) sram_m[a[10:0]][8*b +: 8] = d[8*b +: 8];
            end else begin
                e = sram_m[a[10:0]];
                c = 1'b1;
            end
        end else if (!we) begin
            for (int i = 0; i < 4; i++) e[8*i +: 8] = f_bytes[i];
            c = 1'b1;
        end
        exp_q.push_back(e);
        chk_q.push_back(c);

        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = we;
        addr              = a;
        d_in              = d;
        mem_be            = be;
        rises0 = sck_rises;
        cyc = 0;
        pulses = 0;
        first = 0;
        while (cyc < 300 && (pulses == 0 || cyc < first + hold)) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                pulses++;
                if (first == 0) first = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    c = chk_q.pop_front();
                    if (c) check("d_out", d_out, e);
                end
            end
            memory_is_writing = 1'($urandom_range(0, 1));
            addr   = $urandom;
            d_in   = $urandom;
            mem_be = 4'($urandom_range(0, 15));
        end
        memory_access = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
        end
        check("pulses", 32'(pulses), 32'd1);
        if (!ext || we) begin
            check("latency", 32'(first), 32'd1);
        end else begin
            check("ext_latency_le_132", (first > 0 && first <= 132) ? 32'd1 : 32'd0, 32'd1);
            check("mosi_cmd_addr", f_cmd, {8'h03, a[21:0], 2'b00});
        end
        if (ext && we) check("ext_write_no_sck", 32'(sck_rises - rises0), 32'd0);
        check("cs_n_idle", 32'(ext_cs_n), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  v;
        logic [31:0] ra;
        logic        rw;
        int          pulses;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d_out", d_out, 32'd0);
        check("rst_cs_n", 32'(ext_cs_n), 32'd1);
        check("rst_sck", 32'(ext_sck), 32'd0);
        check("rst_mosi", 32'(ext_mosi), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Passthrough, with a request held high that must be ignored.
        set_programming_mode = 1'b1;
        pt_drive = 1'b1;
        memory_access = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            prog_cs_n = v[2];
            prog_sck  = v[1];
            prog_mosi = v[0];
            #1;
            check("pt_pins", 32'({ext_cs_n, ext_sck, ext_mosi}), 32'(v));
            @(negedge clk);
            check("pt_no_valid", 32'(out_valid), 32'd0);
        end
        prog_cs_n = 1'b1;
        prog_sck  = 1'b0;
        prog_mosi = 1'b0;
        pt_miso = 1'b0;
        #1 check("pt_miso0", 32'(prog_miso), 32'd0);
        pt_miso = 1'b1;
        #1 check("pt_miso1", 32'(prog_miso), 32'd1);
        memory_access = 1'b0;
        @(negedge clk);
        set_programming_mode = 1'b0;
        #1 check("miso_off_mode", 32'(prog_miso), 32'd0);
        pt_drive = 1'b0;
        @(negedge clk);

        // Byte enables.
        run_txn(1'b1, 32'd5, 32'hAABBCCDD, 4'hF, 0);
        run_txn(1'b1, 32'd5, 32'h11223344, 4'b0101, 1);
        run_txn(1'b0, 32'd5, 32'd0, 4'h0, 0);
        check("be_merge", d_out, 32'hAA22CC44);

        // SRAM sweep.
        for (int i = 0; i < 2048; i++) begin
            run_txn(1'b1, 32'(i), 32'(i), 4'hF, 0);
            run_txn(1'b0, 32'(i), 32'd0, 4'h0, 0);
        end

        // Known external read.
        f_bytes[0] = 8'h78;
        f_bytes[1] = 8'h56;
        f_bytes[2] = 8'h34;
        f_bytes[3] = 8'h12;
        run_txn(1'b0, 32'h1000, 32'd0, 4'h0, 0);
        check("ext_known_word", d_out, 32'h12345678);
        check("ext_known_cmd", f_cmd, 32'h03004000);

        // Random mixed traffic.
        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 2) begin
                ra = $urandom;
                if (ra < 32'h800) ra = ra + 32'h800;
                for (int i = 0; i < 4; i++) f_bytes[i] = 8'($urandom);
            end else begin
                ra = 32'($urandom_range(0, 2047));
            end
            run_txn(rw, ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Reset in the middle of an external read.
        @(negedge clk);
        memory_access = 1'b1;
        memory_is_writing = 1'b0;
        addr = 32'h2000;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_n", 32'(ext_cs_n), 32'd1);
        check("rst_mid_sck", 32'(ext_sck), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        if (out_valid) pulses++;
        rst = 1'b0;
        memory_access = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_mid_no_valid", 32'(pulses), 32'd0);
        run_txn(1'b0, 32'd7, 32'd0, 4'h0, 0);

        // Programming mode rising in the middle of an external read.
        @(negedge clk);
        memory_access = 1'b1;
        memory_is_writing = 1'b0;
        addr = 32'h3000;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        set_programming_mode = 1'b1;
        #1 check("mode_abort_cs_n", 32'(ext_cs_n), 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mode_abort_state", 32'(dbg_state), 32'(ST_IDLE));
        memory_access = 1'b0;
        @(negedge clk);
        set_programming_mode = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mode_abort_cs_n_after", 32'(ext_cs_n), 32'd1);
        check("mode_abort_no_valid", 32'(pulses), 32'd0);
        run_txn(1'b0, 32'h7FF, 32'd0, 4'h0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
